// File: rtl/stack_burst_feeder.sv
// stack_burst_feeder
//   Upstream command stage for the 4-entry nibble stack. It collects one
//   transaction of host commands into a small buffer. It then replays that
//   buffer to the stack as a single contiguous IN_VALID burst. Finally it
//   returns the stack's sum to the host as a one-cycle result, or flags that
//   the stack was empty when no sum arrives before the timeout.
//
// Ports
//   CLK, RESET            clock; synchronous active-high reset (shared with the stack)
//   CMD_VALID/CMD_READY   host command handshake
//   CMD_OP, CMD_DATA      1 = push CMD_DATA, 0 = pop
//   CMD_LAST              final command of the transaction
//   OP, IN, IN_VALID      command burst to the stack
//   OUT, OUT_VALID        sum returned by the stack
//   RES_VALID             one-cycle result pulse to the host
//   RES_DATA              stack sum, or 0 when the stack was empty
//   RES_EMPTY             qualifies RES_VALID: no sum was produced
module stack_burst_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_OP,
    input  logic [3:0] CMD_DATA,
    input  logic       CMD_LAST,
    output logic       OP,
    output logic [3:0] IN,
    output logic       IN_VALID,
    input  logic [5:0] OUT,
    input  logic       OUT_VALID,
    output logic       RES_VALID,
    output logic [5:0] RES_DATA,
    output logic       RES_EMPTY
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_WAIT, S_REPORT} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [CW-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [4:0]      r_buf [DEPTH];

    logic            r_cmd_ready, w_cmd_ready_nxt;
    logic            r_op, w_op_nxt;
    logic [3:0]      r_in, w_in_nxt;
    logic            r_in_valid, w_in_valid_nxt;
    logic            r_res_valid, w_res_valid_nxt;
    logic [5:0]      r_res_data, w_res_data_nxt;
    logic            r_res_empty, w_res_empty_nxt;

    logic            w_accept;
    logic            w_full;
    logic [4:0]      w_rd_entry;

    assign w_accept   = (r_state == S_COLLECT) && r_cmd_ready && CMD_VALID;
    assign w_full     = (r_count == CW'(DEPTH - 1));
    assign w_rd_entry = r_buf[r_rd_ptr[PW-1:0]];

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_timer_nxt     = r_timer;
        w_cmd_ready_nxt = r_cmd_ready;
        w_op_nxt        = r_op;
        w_in_nxt        = r_in;
        w_in_valid_nxt  = r_in_valid;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_empty_nxt = r_res_empty;

        case (r_state)
            S_COLLECT: begin
                w_cmd_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_count_nxt = r_count + CW'(1);
                    if (CMD_LAST || w_full) begin
                        w_state_nxt     = S_ISSUE;
                        w_cmd_ready_nxt = 1'b0;
                        w_in_valid_nxt  = 1'b1;
                        w_rd_ptr_nxt    = CW'(1);
                        // Entry 0 goes out on the accepting edge. For a
                        // one-command transaction it is not yet in the buffer,
                        // so it is taken straight from the host inputs.
                        if (r_count == '0) begin
                            w_op_nxt = CMD_OP;
                            w_in_nxt = CMD_DATA;
                        end else begin
                            w_op_nxt = r_buf[0][4];
                            w_in_nxt = r_buf[0][3:0];
                        end
                    end
                end
            end
            S_ISSUE: begin
                w_cmd_ready_nxt = 1'b0;
                if (r_rd_ptr == r_count) begin
                    w_in_valid_nxt = 1'b0;
                    w_op_nxt       = 1'b0;
                    w_in_nxt       = '0;
                    w_timer_nxt    = '0;
                    w_state_nxt    = S_WAIT;
                end else begin
                    w_op_nxt     = w_rd_entry[4];
                    w_in_nxt     = w_rd_entry[3:0];
                    w_rd_ptr_nxt = r_rd_ptr + CW'(1);
                end
            end
            S_WAIT: begin
                w_cmd_ready_nxt = 1'b0;
                if (OUT_VALID) begin
                    w_res_data_nxt  = OUT;
                    w_res_empty_nxt = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_REPORT;
                end else if (r_timer == TW'(TIMEOUT)) begin
                    w_res_data_nxt  = '0;
                    w_res_empty_nxt = 1'b1;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_REPORT;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_REPORT: begin
                w_res_valid_nxt = 1'b0;
                w_res_empty_nxt = 1'b0;
                w_count_nxt     = '0;
                w_cmd_ready_nxt = 1'b1;
                w_state_nxt     = S_COLLECT;
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_COLLECT;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_timer     <= '0;
            r_cmd_ready <= 1'b0;
            r_op        <= 1'b0;
            r_in        <= '0;
            r_in_valid  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_empty <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_timer     <= w_timer_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_op        <= w_op_nxt;
            r_in        <= w_in_nxt;
            r_in_valid  <= w_in_valid_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_empty <= w_res_empty_nxt;
        end
    end

    // Buffer storage has no reset; its contents are only read below r_count.
    always_ff @(posedge CLK) begin
        if (!RESET && w_accept) begin
            r_buf[r_count[PW-1:0]] <= {CMD_OP, CMD_DATA};
        end
    end

    assign CMD_READY = r_cmd_ready;
    assign OP        = r_op;
    assign IN        = r_in;
    assign IN_VALID  = r_in_valid;
    assign RES_VALID = r_res_valid;
    assign RES_DATA  = r_res_data;
    assign RES_EMPTY = r_res_empty;

endmodule
